// File: rtl/filter_dispatch_scheduler.sv
// filter_dispatch_scheduler
// Sequences one home-particle pass through the filter bank: round-robin
// neighbour -> filter input grant, round-robin filter -> force-pipeline output
// grant, and a one-cycle neighbour-register release pulse once the bank has
// drained after the last neighbour.
// Optional feature: define FILTER_DISPATCH_PERF_EN to add the o_stall_cycles
// counter (cycles a valid neighbour waited in DISPATCH with no ready filter).
module filter_dispatch_scheduler #(
  parameter int NUM_FILTERS = 7
`ifdef FILTER_DISPATCH_PERF_EN
  , parameter int STALL_CNT_WIDTH = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_nb_valid,
  input  logic                   i_nb_last,
  output logic                   o_nb_ready,
  input  logic [NUM_FILTERS-1:0] i_filter_ready,
  input  logic [NUM_FILTERS-1:0] i_filter_empty,
  input  logic [NUM_FILTERS-1:0] i_filter_out_valid,
  input  logic                   i_force_ready,
  output logic [NUM_FILTERS-1:0] o_filter_input_arb_result,
  output logic [NUM_FILTERS-1:0] o_filter_output_arb_result,
  output logic                   o_nb_reg_release_flag,
  output logic                   o_busy
`ifdef FILTER_DISPATCH_PERF_EN
  , output logic [STALL_CNT_WIDTH-1:0] o_stall_cycles
`endif
);

  localparam int PTR_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [PTR_W-1:0] in_ptr_r;
  logic [PTR_W-1:0] out_ptr_r;
  logic             drain_cnt_r;
  logic [PTR_W-1:0] in_idx_s;
  logic [PTR_W-1:0] out_idx_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             drained_s;

  // First requester at index >= ptr, wrapping past NUM_FILTERS-1 back to 0.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_FILTERS-1:0] req,
                                               input logic [PTR_W-1:0]       ptr);
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] idx_v;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_FILTERS) begin
        idx = idx - NUM_FILTERS;
      end
      idx_v = PTR_W'(idx);
      if (!found && req[idx_v]) begin
        pick  = idx_v;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_FILTERS-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_FILTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
  endfunction

  // Grant decode and status outputs; output grant is forced off while in reset.
  always_comb begin
    drained_s                  = (&i_filter_empty) & ~(|i_filter_out_valid);
    o_nb_ready                 = (state_r == DISPATCH) & (|i_filter_ready);
    in_fire_s                  = i_nb_valid & o_nb_ready;
    in_idx_s                   = rr_pick(i_filter_ready, in_ptr_r);
    out_fire_s                 = rst_n & i_force_ready & (|i_filter_out_valid);
    out_idx_s                  = rr_pick(i_filter_out_valid, out_ptr_r);
    o_filter_input_arb_result  = in_fire_s ? onehot(in_idx_s) : '0;
    o_filter_output_arb_result = out_fire_s ? onehot(out_idx_s) : '0;
    o_nb_reg_release_flag      = (state_r == RELEASE);
    o_busy                     = (state_r != IDLE);
  end

  // Pass sequencing FSM plus round-robin pointers and drain qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ptr_r    <= '0;
      out_ptr_r   <= '0;
      drain_cnt_r <= 1'b0;
    end else begin
      if (in_fire_s) begin
        in_ptr_r <= next_ptr(in_idx_s);
      end
      if (out_fire_s) begin
        out_ptr_r <= next_ptr(out_idx_s);
      end
      case (state_r)
        IDLE: begin
          drain_cnt_r <= 1'b0;
          if (i_start) begin
            state_r <= DISPATCH;
          end
        end
        DISPATCH: begin
          drain_cnt_r <= 1'b0;
          if (in_fire_s && i_nb_last) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          // drained must hold two consecutive cycles to cover status latency
          if (drained_s) begin
            if (drain_cnt_r) begin
              state_r     <= RELEASE;
              drain_cnt_r <= 1'b0;
            end else begin
              drain_cnt_r <= 1'b1;
            end
          end else begin
            drain_cnt_r <= 1'b0;
          end
        end
        RELEASE: begin
          drain_cnt_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          drain_cnt_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef FILTER_DISPATCH_PERF_EN
  // Saturating count of cycles a valid neighbour stalled for lack of a ready filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stall_cycles <= '0;
    end else if (state_r == IDLE && i_start) begin
      o_stall_cycles <= '0;
    end else if (state_r == DISPATCH && i_nb_valid && !o_nb_ready &&
                 o_stall_cycles != {STALL_CNT_WIDTH{1'b1}}) begin
      o_stall_cycles <= o_stall_cycles + STALL_CNT_WIDTH'(1);
    end else begin
      o_stall_cycles <= o_stall_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_filter_dispatch_scheduler.sv
// Testbench for filter_dispatch_scheduler: directed scenarios followed by
// randomized traffic, checked against a behavioural model through a
// per-cycle expectation queue consumed by an independent monitor.
module tb_filter_dispatch_scheduler;

  localparam int N = 7;
  localparam logic [N-1:0] ALL = {N{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic         i_nb_valid;
  logic         i_nb_last;
  logic         o_nb_ready;
  logic [N-1:0] i_filter_ready;
  logic [N-1:0] i_filter_empty;
  logic [N-1:0] i_filter_out_valid;
  logic         i_force_ready;
  logic [N-1:0] o_filter_input_arb_result;
  logic [N-1:0] o_filter_output_arb_result;
  logic         o_nb_reg_release_flag;
  logic         o_busy;
`ifdef FILTER_DISPATCH_PERF_EN
  logic [15:0]  o_stall_cycles;
`endif

  filter_dispatch_scheduler #(.NUM_FILTERS(N)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .i_start                    (i_start),
    .i_nb_valid                 (i_nb_valid),
    .i_nb_last                  (i_nb_last),
    .o_nb_ready                 (o_nb_ready),
    .i_filter_ready             (i_filter_ready),
    .i_filter_empty             (i_filter_empty),
    .i_filter_out_valid         (i_filter_out_valid),
    .i_force_ready              (i_force_ready),
    .o_filter_input_arb_result  (o_filter_input_arb_result),
    .o_filter_output_arb_result (o_filter_output_arb_result),
    .o_nb_reg_release_flag      (o_nb_reg_release_flag),
    .o_busy                     (o_busy)
`ifdef FILTER_DISPATCH_PERF_EN
    , .o_stall_cycles           (o_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic         rdy;
    logic [N-1:0] ig;
    logic [N-1:0] og;
    logic         rel;
    logic         busy;
    logic [15:0]  stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Reference model: pass phase, fairness pointers, consecutive-drained run, stall count
  localparam int P_IDLE = 0, P_DISP = 1, P_DRAIN = 2, P_REL = 3;
  int m_phase = P_IDLE;
  int m_in    = 0;
  int m_out   = 0;
  int m_run   = 0;
  int m_stall = 0;

  function automatic int rr_first(input logic [N-1:0] req, input int ptr);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (ptr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] hot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    exp_t e;
    int   gi;
    int   go;
    logic fire;
    e.cyc = cyc_no;
    if (!rst_n) begin
      e.rdy = 1'b0; e.ig = '0; e.og = '0; e.rel = 1'b0; e.busy = 1'b0; e.stall = '0;
      exp_q.push_back(e);
      m_phase = P_IDLE; m_in = 0; m_out = 0; m_run = 0; m_stall = 0;
      return;
    end
    e.busy  = (m_phase != P_IDLE);
    e.rel   = (m_phase == P_REL);
    e.stall = 16'(m_stall);
    e.rdy   = (m_phase == P_DISP) && (i_filter_ready != '0);
    fire    = i_nb_valid && e.rdy;
    gi      = rr_first(i_filter_ready, m_in);
    e.ig    = fire ? hot(gi) : '0;
    go      = rr_first(i_filter_out_valid, m_out);
    e.og    = (i_force_ready && go >= 0) ? hot(go) : '0;
    exp_q.push_back(e);
    if (fire) m_in = (gi + 1) % N;
    if (i_force_ready && go >= 0) m_out = (go + 1) % N;
    case (m_phase)
      P_IDLE:  if (i_start) begin m_phase = P_DISP; m_stall = 0; end
      P_DISP: begin
        if (i_nb_valid && !e.rdy && m_stall < 65535) m_stall++;
        if (fire && i_nb_last) begin m_phase = P_DRAIN; m_run = 0; end
      end
      P_DRAIN: begin
        if (i_filter_empty == ALL && i_filter_out_valid == '0) m_run++;
        else m_run = 0;
        if (m_run == 2) m_phase = P_REL;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic apply(input logic r, input logic st, input logic v, input logic l,
                       input logic [N-1:0] rdy, input logic [N-1:0] emp,
                       input logic [N-1:0] ov, input logic fr);
    @(posedge clk);
    #1;
    cyc_no++;
    rst_n = r; i_start = st; i_nb_valid = v; i_nb_last = l;
    i_filter_ready = rdy; i_filter_empty = emp; i_filter_out_valid = ov; i_force_ready = fr;
    model_step();
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Monitor: compare presented outputs against the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("nb_ready",   e.cyc, 32'(o_nb_ready),                 32'(e.rdy));
      chk("in_grant",   e.cyc, 32'(o_filter_input_arb_result),  32'(e.ig));
      chk("out_grant",  e.cyc, 32'(o_filter_output_arb_result), 32'(e.og));
      chk("release",    e.cyc, 32'(o_nb_reg_release_flag),      32'(e.rel));
      chk("busy",       e.cyc, 32'(o_busy),                     32'(e.busy));
`ifdef FILTER_DISPATCH_PERF_EN
      chk("stall_cnt",  e.cyc, 32'(o_stall_cycles),             32'(e.stall));
`endif
    end
  end

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_nb_valid = 1'b0; i_nb_last = 1'b0;
    i_filter_ready = '0; i_filter_empty = ALL; i_filter_out_valid = '0; i_force_ready = 1'b0;

    // reset held, with traffic present: everything must stay 0
    repeat (2) apply(1'b0, 1'b1, 1'b1, 1'b0, ALL, '0, 7'b0010010, 1'b1);
    repeat (2) apply(1'b1, 1'b0, 1'b0, 1'b0, '0, ALL, '0, 1'b0);

    // reset asserted mid-DISPATCH while both grants are active
    apply(1'b1, 1'b1, 1'b0, 1'b0, ALL, ALL, '0, 1'b0);
    repeat (2) apply(1'b1, 1'b0, 1'b1, 1'b0, ALL, ALL, 7'b0001000, 1'b1);
    apply(1'b0, 1'b0, 1'b1, 1'b0, ALL, ALL, 7'b0001000, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, ALL, '0, 1'b0);

    // 10 neighbours, all filters ready: 0..6,0,1,2; then drain with 1-cycle status lag
    apply(1'b1, 1'b1, 1'b0, 1'b0, ALL, ALL, '0, 1'b0);
    for (int k = 0; k < 10; k++) apply(1'b1, 1'b0, 1'b1, (k == 9), ALL, ALL, '0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, ALL, 7'b1111110, '0, 1'b0);
    repeat (5) apply(1'b1, 1'b1, 1'b0, 1'b0, ALL, ALL, '0, 1'b0);

    // in_ptr=3 then sparse ready 0100100 -> filter 5; out_ptr=6 with valid 1000001 -> 6,0,6
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, ALL, '0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, ALL, ALL, '0, 1'b0);
    repeat (3) apply(1'b1, 1'b0, 1'b1, 1'b0, ALL, ALL, '0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 7'b0100100, ALL, 7'b0100000, 1'b1);
    repeat (3) apply(1'b1, 1'b0, 1'b0, 1'b0, ALL, ALL, 7'b1000001, 1'b1);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 7'b0100100, ALL, '0, 1'b0);

    // stalls: valid neighbour with no ready filter for 5 cycles, then finish pass and restart
    repeat (5) apply(1'b1, 1'b0, 1'b1, 1'b0, '0, ALL, '0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 7'b0000010, ALL, '0, 1'b0);
    repeat (4) apply(1'b1, 1'b0, 1'b0, 1'b0, '0, ALL, '0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, '0, ALL, '0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, ALL, '0, 1'b0);

    // randomized traffic, including occasional mid-pass resets
    for (int c = 0; c < 4000; c++) begin
      apply(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 4) == 0) ? 7'(0) : 7'($urandom),
            ($urandom_range(0, 1) == 0) ? ALL : 7'($urandom),
            ($urandom_range(0, 1) == 0) ? 7'(0) : 7'($urandom),
            ($urandom_range(0, 2) != 0));
    end

    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, ALL, '0, 1'b0);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
